// File: rtl/timer_controller.sv
// Host-side controller that turns 64-bit mtime/mtimecmp requests into ordered 32-bit timer bus accesses.
// Writes use carry-safe or glitch-safe ordering, and reads re-check the hi word to detect a lo-to-hi rollover.
module timer_controller #(
  parameter int MAX_RETRY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic [1:0]  reqOp,
  input  logic [63:0] reqData,
  output logic        respValid,
  output logic [63:0] respData,
  output logic        respError,
  output logic [3:0]  timerAddr,
  output logic [31:0] timerWriteData,
  output logic        timerReadEnable,
  output logic        timerWriteEnable,
  input  logic [31:0] timerReadData
);

  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

  typedef enum logic [2:0] {IDLE, W1, W2, W3, RHI1, RLO, RHI2, RESP} state_t;

  state_t        state_reg;
  state_t        state_next;
  logic          accept;
  logic          cmp_reg;
  logic [63:0]   data_reg;
  logic [31:0]   hi1_reg;
  logic [31:0]   lo_reg;
  logic [RW-1:0] retry_reg;
  logic          hi_match;
  logic          retry_now;

  assign accept    = reqValid && reqReady;
  assign hi_match  = (timerReadData == hi1_reg);
  assign retry_now = (state_reg == RHI2) && !hi_match && (retry_reg < RETRY_LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (accept) state_next = reqOp[1] ? W1 : RHI1;
      W1:      state_next = W2;
      W2:      state_next = W3;
      W3:      state_next = RESP;
      RHI1:    state_next = RLO;
      RLO:     state_next = RHI2;
      RHI2:    state_next = retry_now ? RHI1 : RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Bus drive decodes only the state and the latched target; cmp_reg selects mtimecmp.
  always_comb begin
    reqReady         = (state_reg == IDLE) && !rst;
    respValid        = (state_reg == RESP) && !rst;
    timerReadEnable  = 1'b0;
    timerWriteEnable = 1'b0;
    timerAddr        = 4'h0;
    timerWriteData   = 32'h0;
    unique case (state_reg)
      W1: begin
        timerWriteEnable = 1'b1;
        timerAddr        = cmp_reg ? 4'hC : 4'h0;
        timerWriteData   = cmp_reg ? 32'hFFFF_FFFF : 32'h0;
      end
      W2: begin
        timerWriteEnable = 1'b1;
        timerAddr        = cmp_reg ? 4'h8 : 4'h4;
        timerWriteData   = cmp_reg ? data_reg[31:0] : data_reg[63:32];
      end
      W3: begin
        timerWriteEnable = 1'b1;
        timerAddr        = cmp_reg ? 4'hC : 4'h0;
        timerWriteData   = cmp_reg ? data_reg[63:32] : data_reg[31:0];
      end
      RHI1, RHI2: begin
        timerReadEnable = 1'b1;
        timerAddr       = cmp_reg ? 4'hC : 4'h4;
      end
      RLO: begin
        timerReadEnable = 1'b1;
        timerAddr       = cmp_reg ? 4'h8 : 4'h0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmp_reg   <= 1'b0;
      data_reg  <= 64'h0;
      hi1_reg   <= 32'h0;
      lo_reg    <= 32'h0;
      retry_reg <= '0;
      respData  <= 64'h0;
      respError <= 1'b0;
    end else begin
      if (accept) begin
        cmp_reg   <= reqOp[0];
        data_reg  <= reqData;
        retry_reg <= '0;
      end
      if (state_reg == RHI1) hi1_reg <= timerReadData;
      if (state_reg == RLO) lo_reg <= timerReadData;
      if (retry_now) retry_reg <= retry_reg + RW'(1);
      if (state_reg == W3) begin
        respData  <= 64'h0;
        respError <= 1'b0;
      end
      // On a match hi2 equals hi1, so {hi2, lo} covers both outcomes.
      if (state_reg == RHI2 && !retry_now) begin
        respData  <= {timerReadData, lo_reg};
        respError <= !hi_match;
      end
    end
  end

endmodule
